// File: rtl/digit_serial_alu_unit.sv
// digit_serial_alu_unit: digit-serial AND/OR/XOR/NEG/ABS/SUB, CHUNK bits per clock through one reused adder slice.
// Define DIGIT_SERIAL_SAT_EN to saturate NEG/ABS/SUB overflow instead of wrapping.
module digit_serial_alu_unit #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             valid,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             ovf,
   output logic             cout,
   output logic             err
);
   localparam int N  = WIDTH / CHUNK;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [2:0] OP_AND = 3'd0, OP_OR = 3'd1, OP_XOR = 3'd2;
   localparam logic [2:0] OP_NEG = 3'd3, OP_ABS = 3'd4, OP_SUB = 3'd5;
   localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

   if (CHUNK < 1 || WIDTH % CHUNK != 0) begin : g_bad_cfg
      $error("digit_serial_alu_unit: WIDTH must be a multiple of CHUNK");
   end

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q, res_q;
   logic [2:0]       op_q;
   logic [CW-1:0]    cnt_q;
   logic             carry_q, valid_q, zero_q, ovf_q, cout_q, err_q;

   logic [CHUNK-1:0] a_c, b_c, x_c, y_c, chunk_d;
   logic [CHUNK:0]   sum_d;
   logic [WIDTH-1:0] ins_d, fin_d;
   logic             inv_a, last, ovf_d;

   always_comb begin
      a_c     = a_q[cnt_q*CHUNK +: CHUNK];
      b_c     = b_q[cnt_q*CHUNK +: CHUNK];
      inv_a   = op_q == OP_NEG || (op_q == OP_ABS && a_q[WIDTH-1]);
      x_c     = inv_a ? ~a_c : a_c;
      y_c     = op_q == OP_SUB ? ~b_c : '0;
      sum_d   = {1'b0, x_c} + {1'b0, y_c} + {{CHUNK{1'b0}}, carry_q};
      chunk_d = op_q == OP_AND ? a_c & b_c :
                op_q == OP_OR  ? a_c | b_c :
                op_q == OP_XOR ? a_c ^ b_c :
                op_q <= OP_SUB ? sum_d[CHUNK-1:0] : '0;
      ins_d   = res_q;
      ins_d[cnt_q*CHUNK +: CHUNK] = chunk_d;
      last    = cnt_q == CW'(N-1);
      // ovf_d is only meaningful on the last chunk, once ins_d holds the full result
      ovf_d   = (op_q == OP_NEG || op_q == OP_ABS) ? a_q == MIN_V :
                op_q == OP_SUB ? (a_q[WIDTH-1] != b_q[WIDTH-1]) && (ins_d[WIDTH-1] != a_q[WIDTH-1]) : 1'b0;
`ifdef DIGIT_SERIAL_SAT_EN
      fin_d   = !ovf_d ? ins_d : (op_q == OP_SUB && a_q[WIDTH-1]) ? MIN_V : ~MIN_V;
`else
      fin_d   = ins_d;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         valid_q <= 1'b0;
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
         cout_q  <= 1'b0;
         err_q   <= 1'b0;
      end else if (state_q == IDLE) begin
         if (start) begin
            state_q <= BUSY;
            a_q     <= a;
            b_q     <= b;
            op_q    <= op;
            cnt_q   <= '0;
            carry_q <= op == OP_NEG || op == OP_SUB || (op == OP_ABS && a[WIDTH-1]);
            valid_q <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
         end
      end else begin
         res_q   <= last ? fin_d : ins_d;
         carry_q <= sum_d[CHUNK];
         cnt_q   <= last ? '0 : cnt_q + 1'b1;
         if (last) begin
            state_q <= IDLE;
            valid_q <= 1'b1;
            zero_q  <= fin_d == '0;
            ovf_q   <= ovf_d;
            cout_q  <= op_q == OP_SUB && sum_d[CHUNK];
            err_q   <= op_q[2] & op_q[1];
         end
      end
   end

   assign busy   = state_q == BUSY;
   assign valid  = valid_q;
   assign result = res_q;
   assign zero   = zero_q;
   assign ovf    = ovf_q;
   assign cout   = cout_q;
   assign err    = err_q;
endmodule
